// File: rtl/vc_wrr_scheduler_pkg.sv
// Shared constants, mode codes and FSM states for the QoS VC read-side scheduler.
package vc_wrr_scheduler_pkg;

  localparam int unsigned QUEUE_QUANTITY    = 4;
  localparam int unsigned MAX_WEIGHT        = 64;
  localparam int unsigned TABLE_SIZE        = 8;
  localparam int unsigned TIPOS_ROUND_ROBIN = 3;

  typedef enum logic [1:0] {
    RR_PLAIN  = 2'd0,
    RR_WEIGHT = 2'd1,
    RR_TABLE  = 2'd2
  } rr_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_SERVE
  } state_t;

  function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/vc_wrr_scheduler_rr_prio_finder.sv
// Rotating first-set search: finds the first set req bit at or after start, wrapping.
module vc_wrr_scheduler_rr_prio_finder #(
  parameter int unsigned N = 4,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         hit,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  assign dbl = {req, req};
  assign rot = N'(dbl >> start);

  always_comb begin
    int unsigned sum;
    hit = 1'b0;
    idx = '0;
    sum = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit && rot[i]) begin
        hit = 1'b1;
        sum = 32'(start) + i;
        idx = W'((sum >= N) ? sum - N : sum);
      end
    end
  end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Read-side scheduler for the QoS VC FIFO bank: RR, weighted RR or arbitration-table policy,
// driving one-hot pop strobes and tagging each popped word with its VC index.
module vc_wrr_scheduler
  import vc_wrr_scheduler_pkg::*;
#(
  parameter int unsigned QUEUE_QUANTITY    = vc_wrr_scheduler_pkg::QUEUE_QUANTITY,
  parameter int unsigned MAX_WEIGHT        = vc_wrr_scheduler_pkg::MAX_WEIGHT,
  parameter int unsigned TABLE_SIZE        = vc_wrr_scheduler_pkg::TABLE_SIZE,
  parameter int unsigned TIPOS_ROUND_ROBIN = vc_wrr_scheduler_pkg::TIPOS_ROUND_ROBIN,
  localparam int unsigned Q  = QUEUE_QUANTITY,
  localparam int unsigned T  = TABLE_SIZE,
  localparam int unsigned QW = $clog2(QUEUE_QUANTITY),
  localparam int unsigned TW = $clog2(TABLE_SIZE),
  localparam int unsigned WW = $clog2(MAX_WEIGHT),
  localparam int unsigned MW = $clog2(TIPOS_ROUND_ROBIN),
  localparam int unsigned PW = (TW > QW) ? TW : QW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enb,
  input  logic            iniciar,
  input  logic            rd_en,
  input  logic [Q-1:0]    empty,
  input  logic [MW-1:0]   mem_seleccion_roundRobin,
  input  logic [Q*WW-1:0] mem_pesos,
  input  logic [T*WW-1:0] mem_pesosArbitraje,
  input  logic [T*QW-1:0] mem_selecciones,
  output logic [Q-1:0]    pop,
  output logic [QW-1:0]   vc_id,
  output logic            valid,
  output logic            idle
);

  state_t          state_q, state_d;
  logic [MW-1:0]   mode_q;
  logic [Q*WW-1:0] pesos_q;
  logic [T*WW-1:0] pw_q;
  logic [T*QW-1:0] sel_q;
  logic [PW-1:0]   ptr_q;
  logic [QW-1:0]   grant_q;
  logic [WW-1:0]   cnt_q;

  logic            is_wrr, is_table;
  logic [Q-1:0]    req_q;
  logic [T-1:0]    req_t;
  logic [QW-1:0]   start_q, idx_q;
  logic [TW-1:0]   start_t, idx_t;
  logic            hit_q, hit_t, hit;
  logic [QW-1:0]   hit_vc;
  logic [PW-1:0]   hit_ptr;
  logic [WW-1:0]   quota;

  assign is_wrr   = (mode_q == RR_WEIGHT);
  assign is_table = (mode_q == RR_TABLE);

  always_comb begin
    req_q = '0;
    for (int unsigned v = 0; v < Q; v++)
      req_q[v] = !empty[v] && (!is_wrr || (pesos_q[v*WW +: WW] != '0));
  end

  always_comb begin
    req_t = '0;
    for (int unsigned e = 0; e < T; e++)
      req_t[e] = (pw_q[e*WW +: WW] != '0) && !empty[sel_q[e*QW +: QW]];
  end

  // Mode 3 falls through to plain RR since only WEIGHT and TABLE are decoded.
  assign start_q = QW'(wrap_next(32'(ptr_q), Q));
  assign start_t = TW'(wrap_next(32'(ptr_q), T));

  vc_wrr_scheduler_rr_prio_finder #(.N(Q)) u_find_vc (
    .req   (req_q),
    .start (start_q),
    .hit   (hit_q),
    .idx   (idx_q)
  );

  vc_wrr_scheduler_rr_prio_finder #(.N(T)) u_find_tbl (
    .req   (req_t),
    .start (start_t),
    .hit   (hit_t),
    .idx   (idx_t)
  );

  always_comb begin
    if (is_table) begin
      hit     = hit_t;
      hit_vc  = sel_q[idx_t*QW +: QW];
      hit_ptr = PW'(idx_t);
      quota   = pw_q[idx_t*WW +: WW];
    end else begin
      hit     = hit_q;
      hit_vc  = idx_q;
      hit_ptr = PW'(idx_q);
      quota   = is_wrr ? pesos_q[idx_q*WW +: WW] : WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      pesos_q <= '0;
      pw_q    <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else if (enb) begin
      state_q <= state_d;
      if (state_q == S_IDLE && iniciar) begin
        mode_q  <= mem_seleccion_roundRobin;
        pesos_q <= mem_pesos;
        pw_q    <= mem_pesosArbitraje;
        sel_q   <= mem_selecciones;
      end
      if (state_q == S_SELECT && iniciar && hit) begin
        grant_q <= hit_vc;
        cnt_q   <= quota;
        ptr_q   <= hit_ptr;
      end
      if (state_q == S_SERVE && valid)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (iniciar) state_d = S_SELECT;
      S_SELECT: begin
        if (!iniciar)  state_d = S_IDLE;
        else if (hit)  state_d = S_SERVE;
      end
      S_SERVE: begin
        if (!iniciar)                                         state_d = S_IDLE;
        else if (empty[grant_q] || (valid && cnt_q == WW'(1))) state_d = S_SELECT;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    if (state_q == S_SERVE && rd_en && enb && !empty[grant_q])
      pop[grant_q] = 1'b1;
    vc_id = grant_q;
    idle  = (state_q == S_IDLE) || (state_q == S_SELECT && !hit);
  end

  assign valid = |pop;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Bench for vc_wrr_scheduler: behavioural scheduler model plus directed policy sequences and random stress.
module tb_vc_wrr_scheduler;

  localparam int Q = 4;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst, enb, iniciar, rd_en;
  logic [3:0]  empty;
  logic [1:0]  mode;
  logic [23:0] pesos;
  logic [47:0] pw;
  logic [15:0] sel;
  logic [3:0]  pop;
  logic [1:0]  vc_id;
  logic        valid, idle;

  int checks = 0;
  int errors = 0;

  // model state: phase 0=idle 1=select 2=serve
  int fcnt[4];
  int m_ph, m_ptr, m_grant, m_left;
  int s_mode;
  int s_w[4];
  int s_pw[8];
  int s_sel[8];
  int refill_pct;
  int cyc;
  int seq_vc[$];
  int seq_cyc[$];

  always #5 clk = ~clk;

  vc_wrr_scheduler dut (
    .clk                      (clk),
    .rst                      (rst),
    .enb                      (enb),
    .iniciar                  (iniciar),
    .rd_en                    (rd_en),
    .empty                    (empty),
    .mem_seleccion_roundRobin (mode),
    .mem_pesos                (pesos),
    .mem_pesosArbitraje       (pw),
    .mem_selecciones          (sel),
    .pop                      (pop),
    .vc_id                    (vc_id),
    .valid                    (valid),
    .idle                     (idle)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int seq_at(input int i);
    return (i < seq_vc.size()) ? seq_vc[i] : -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ptr = 0; m_grant = 0; m_left = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: apply FIFO flags, check DUT against model, advance model, wait for next negedge.
  task automatic step();
    int e_pop, e_idle, hit, hidx, hvc, quota, p, was_empty, idx, e, v;
    for (int k = 0; k < Q; k++) empty[k] = (fcnt[k] == 0);
    #1;
    e_pop = 0; hit = 0; hidx = 0; hvc = 0; quota = 0; p = 0;
    if (m_ph == 1) begin
      if (s_mode == 2) begin
        for (int i = 1; i <= T; i++) begin
          e = (m_ptr + i) % T;
          if (!hit && s_pw[e] != 0 && fcnt[s_sel[e]] > 0) begin
            hit = 1; hidx = e; hvc = s_sel[e]; quota = s_pw[e];
          end
        end
      end else begin
        for (int i = 1; i <= Q; i++) begin
          v = (m_ptr + i) % Q;
          if (!hit && fcnt[v] > 0 && (s_mode != 1 || s_w[v] != 0)) begin
            hit = 1; hidx = v; hvc = v; quota = (s_mode == 1) ? s_w[v] : 1;
          end
        end
      end
    end
    e_idle = (m_ph == 0 || (m_ph == 1 && !hit)) ? 1 : 0;
    was_empty = (fcnt[m_grant] == 0) ? 1 : 0;
    if (m_ph == 2 && rd_en && enb && !was_empty) begin
      p = 1;
      e_pop = 1 << m_grant;
    end

    chk("pop", int'(pop), e_pop);
    chk("valid", int'(valid), p);
    chk("idle", int'(idle), e_idle);
    if (p != 0) chk("vc_id", int'(vc_id), m_grant);
    chk("pop_onehot", int'($onehot0(pop)), 1);
    chk("pop_while_empty", int'((pop & empty) != 4'd0), 0);
    if (valid) chk("vc_id_matches_pop", int'(pop[vc_id]), 1);

    if (valid) begin
      idx = -1;
      for (int k = 0; k < Q; k++) if (pop[k]) idx = k;
      seq_vc.push_back(idx);
      seq_cyc.push_back(cyc);
    end

    if (enb) begin
      case (m_ph)
        0: if (iniciar) begin
          s_mode = int'(mode);
          for (int k = 0; k < Q; k++) s_w[k] = int'(pesos[k*6 +: 6]);
          for (int k = 0; k < T; k++) begin
            s_pw[k]  = int'(pw[k*6 +: 6]);
            s_sel[k] = int'(sel[k*2 +: 2]);
          end
          m_ph = 1;
        end
        1: begin
          if (!iniciar) m_ph = 0;
          else if (hit != 0) begin
            m_grant = hvc; m_left = quota; m_ptr = hidx; m_ph = 2;
          end
        end
        default: begin
          if (p != 0) begin
            fcnt[m_grant]--;
            m_left--;
          end
          if (!iniciar) m_ph = 0;
          else if ((p != 0 && m_left == 0) || was_empty != 0) m_ph = 1;
        end
      endcase
    end

    for (int k = 0; k < Q; k++)
      if (fcnt[k] < 60 && $urandom_range(99) < refill_pct) fcnt[k]++;

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_test(input logic [1:0] m, input int c0, input int c1, input int c2, input int c3);
    do_reset();
    mode = m;
    fcnt[0] = c0; fcnt[1] = c1; fcnt[2] = c2; fcnt[3] = c3;
    refill_pct = 0;
    enb = 1'b1; rd_en = 1'b1; iniciar = 1'b1;
    seq_vc.delete();
    seq_cyc.delete();
  endtask

  function automatic logic [5:0] rnd_w();
    int r;
    r = $urandom_range(9);
    if (r == 0) return 6'd0;
    if (r == 1) return 6'd63;
    return 6'($urandom_range(20, 1));
  endfunction

  initial begin
    int exp_rr[4];
    int exp_wrr[9];
    int exp_tbl[8];
    int exp_early[7];
    int run_len, n3;

    rst = 1'b0; enb = 1'b1; iniciar = 1'b0; rd_en = 1'b0;
    empty = '1; mode = '0; pesos = '0; pw = '0; sel = '0;
    refill_pct = 0; cyc = 0;
    for (int k = 0; k < Q; k++) fcnt[k] = 0;
    model_reset();

    #1;
    chk("reset_pop", int'(pop), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_vc_id", int'(vc_id), 0);
    chk("reset_idle", int'(idle), 1);
    @(negedge clk);
    rst = 1'b1;

    // async reset in the middle of a serve cycle
    start_test(2'd0, 100, 100, 100, 100);
    for (int k = 0; k < 10 && m_ph != 2; k++) step();
    for (int k = 0; k < Q; k++) empty[k] = (fcnt[k] == 0);
    #1;
    chk("pre_reset_valid", int'(valid), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_pop", int'(pop), 0);
    chk("async_reset_idle", int'(idle), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    iniciar = 1'b0;
    #1;
    chk("post_reset_idle", int'(idle), 1);
    step();

    // plain RR
    exp_rr = '{1, 2, 3, 0};
    start_test(2'd0, 100, 100, 100, 100);
    run(10);
    chk("rr_pops", seq_vc.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", seq_at(i), exp_rr[i]);
    if (seq_cyc.size() >= 2) chk("rr_bubble", seq_cyc[1] - seq_cyc[0], 2);

    // weighted RR, w = {4,2,1,0}
    exp_wrr = '{1, 1, 2, 0, 0, 0, 0, 1, 1};
    start_test(2'd1, 100, 100, 100, 100);
    pesos = {6'd0, 6'd1, 6'd2, 6'd4};
    run(14);
    for (int i = 0; i < 9; i++) chk("wrr_order", seq_at(i), exp_wrr[i]);
    run(30);
    n3 = 0;
    foreach (seq_vc[i]) if (seq_vc[i] == 3) n3++;
    chk("wrr_vc3_never", n3, 0);

    // arbitration table
    exp_tbl = '{2, 0, 0, 1, 0, 0, 0, 2};
    start_test(2'd2, 100, 100, 100, 100);
    sel = {2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd0};
    pw  = {6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd1, 6'd3};
    run(14);
    for (int i = 0; i < 8; i++) chk("tbl_order", seq_at(i), exp_tbl[i]);

    // early empty discards the remaining quota
    exp_early = '{1, 2, 3, 0, 0, 0, 1};
    start_test(2'd1, 3, 100, 100, 100);
    pesos = {6'd1, 6'd1, 6'd1, 6'd8};
    run(16);
    for (int i = 0; i < 7; i++) chk("early_order", seq_at(i), exp_early[i]);
    if (seq_cyc.size() >= 7) chk("early_gap", seq_cyc[6] - seq_cyc[5], 3);

    // stall with rd_en, freeze with enb, quota preserved
    start_test(2'd1, 100, 0, 0, 0);
    pesos = {6'd0, 6'd0, 6'd0, 6'd10};
    run(5);
    chk("stall_prefix_pops", seq_vc.size(), 3);
    rd_en = 1'b0;
    run(5);
    chk("stall_no_pops", seq_vc.size(), 3);
    rd_en = 1'b1; enb = 1'b0;
    run(4);
    chk("freeze_no_pops", seq_vc.size(), 3);
    enb = 1'b1;
    seq_vc.delete();
    seq_cyc.delete();
    run(12);
    run_len = (seq_cyc.size() > 0) ? 1 : 0;
    while (run_len < seq_cyc.size() && seq_cyc[run_len] == seq_cyc[run_len-1] + 1) run_len++;
    chk("resume_quota", run_len, 7);

    // random stress with config churn while running
    start_test(2'd0, 5, 5, 5, 5);
    refill_pct = 30;
    for (int i = 0; i < 4000; i++) begin
      enb     = ($urandom_range(99) < 93);
      rd_en   = ($urandom_range(99) < 75);
      iniciar = ($urandom_range(99) < 97);
      mode    = 2'($urandom_range(3));
      for (int k = 0; k < Q; k++) pesos[k*6 +: 6] = rnd_w();
      for (int k = 0; k < T; k++) begin
        pw[k*6 +: 6] = rnd_w();
        sel[k*2 +: 2] = 2'($urandom_range(3));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
